// File: rtl/cumsum_window_ctrl_pkg.sv
// ============================================================================
// Module : cumsum_pkg
// Shared register map, bit indices, FSM state encoding and default widths
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cumsum_pkg;

    localparam int DEF_DATA_W = 14;
    localparam int DEF_SUM_W  = 28;
    localparam int DEF_CNT_W  = 16;

    localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] c_ADDR_WINDOW = 2'd1;
    localparam logic [1:0] c_ADDR_STATUS = 2'd2;
    localparam logic [1:0] c_ADDR_RESULT = 2'd3;

    localparam int c_CTRL_START  = 0;
    localparam int c_CTRL_CONT   = 1;
    localparam int c_CTRL_ABORT  = 2;
    localparam int c_CTRL_IRQ_EN = 3;

    localparam int c_STAT_BUSY    = 0;
    localparam int c_STAT_DONE    = 1;
    localparam int c_STAT_OVERRUN = 2;
    localparam int c_STAT_SAT     = 3;
    localparam int c_STAT_CFG_ERR = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_LATCH = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cumsum_window_ctrl_if.sv
// ============================================================================
// Module : cumsum_window_ctrl_if
// Avalon-MM slave register bus used by the window-sum controller
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface cumsum_window_ctrl_if;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;

    modport master (
        output address, write, writedata, read,
        input  readdata
    );

    modport slave (
        input  address, write, writedata, read,
        output readdata
    );
endinterface

`default_nettype wire

// File: rtl/cumsum_window_ctrl_sat_acc.sv
// ============================================================================
// Module : cumsum_sat_acc
// Unsigned accumulator that clamps at all-ones and flags the overflow event
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cumsum_sat_acc
    import cumsum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SUM_W  = DEF_SUM_W
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_clr,
    input  wire logic              i_en,
    input  wire logic [DATA_W-1:0] i_data,
    output logic      [SUM_W-1:0]  o_acc,
    output logic                   o_sat
);

    logic [SUM_W-1:0] r_acc;
    logic [SUM_W:0]   w_sum;

    // One extra bit catches the carry so overflow can be clamped
    assign w_sum = {1'b0, r_acc} + {{(SUM_W + 1 - DATA_W){1'b0}}, i_data};
    assign o_sat = i_en && !i_clr && w_sum[SUM_W];
    assign o_acc = r_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum[SUM_W] ? {SUM_W{1'b1}} : w_sum[SUM_W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/cumsum_window_ctrl.sv
// ============================================================================
// Module : cumsum_window_ctrl
// Sums N ADC samples per window under Avalon-MM control, single-shot or continuous
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cumsum_window_ctrl
    import cumsum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SUM_W  = DEF_SUM_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  wire logic              clk,
    input  wire logic              reset,
    cumsum_window_ctrl_if.slave    bus,
    input  wire logic              sample_valid,
    input  wire logic [DATA_W-1:0] sample_data,
    output logic      [SUM_W-1:0]  cumsum_out,
    output logic                   cumsum_valid,
    output logic                   irq
);

    state_t           r_state, w_state_nxt;
    logic             r_continuous, r_irq_en;
    logic [CNT_W-1:0] r_window_n, r_cnt, w_cnt_next;
    logic             r_done, r_overrun, r_sat, r_cfg_err;
    logic [SUM_W-1:0] r_cumsum_out, w_acc;
    logic             r_cumsum_valid;
    logic [31:0]      r_readdata, w_rd_mux;

    logic w_wr_ctrl, w_wr_window, w_wr_status, w_rd_result;
    logic w_start, w_abort, w_done_clr, w_busy;
    logic w_acc_clr, w_acc_en, w_acc_sat, w_cnt_clr, w_cnt_inc, w_latch, w_cfg_err_set;
    logic w_unused_wdata;

    assign w_wr_ctrl   = bus.write && (bus.address == c_ADDR_CTRL);
    assign w_wr_window = bus.write && (bus.address == c_ADDR_WINDOW);
    assign w_wr_status = bus.write && (bus.address == c_ADDR_STATUS);
    assign w_rd_result = bus.read  && (bus.address == c_ADDR_RESULT);
    assign w_start     = w_wr_ctrl && bus.writedata[c_CTRL_START];
    assign w_abort     = w_wr_ctrl && bus.writedata[c_CTRL_ABORT];
    assign w_done_clr  = w_rd_result || (w_wr_status && bus.writedata[c_STAT_DONE]);
    assign w_busy      = (r_state != S_IDLE);
    assign w_cnt_next  = r_cnt + 1'b1;
    assign w_unused_wdata = ^bus.writedata;

    cumsum_sat_acc #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W)
    ) u_acc (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_acc_clr),
        .i_en   (w_acc_en),
        .i_data (sample_data),
        .o_acc  (w_acc),
        .o_sat  (w_acc_sat)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_acc_clr     = 1'b0;
        w_acc_en      = 1'b0;
        w_cnt_clr     = 1'b0;
        w_cnt_inc     = 1'b0;
        w_latch       = 1'b0;
        w_cfg_err_set = 1'b0;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        if (r_window_n == '0) begin
                            w_cfg_err_set = 1'b1;
                        end else begin
                            w_state_nxt = S_ACCUM;
                            w_acc_clr   = 1'b1;
                            w_cnt_clr   = 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (sample_valid) begin
                        w_acc_en  = 1'b1;
                        w_cnt_inc = 1'b1;
                        if (w_cnt_next == r_window_n) w_state_nxt = S_LATCH;
                    end
                end
                S_LATCH: begin
                    // Samples arriving here are ignored; the next window starts clean
                    w_latch = 1'b1;
                    if (r_continuous) begin
                        w_state_nxt = S_ACCUM;
                        w_acc_clr   = 1'b1;
                        w_cnt_clr   = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_continuous   <= 1'b0;
            r_irq_en       <= 1'b0;
            r_window_n     <= {{(CNT_W-1){1'b0}}, 1'b1};
            r_cnt          <= '0;
            r_done         <= 1'b0;
            r_overrun      <= 1'b0;
            r_sat          <= 1'b0;
            r_cfg_err      <= 1'b0;
            r_cumsum_out   <= '0;
            r_cumsum_valid <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_continuous <= bus.writedata[c_CTRL_CONT];
                r_irq_en     <= bus.writedata[c_CTRL_IRQ_EN];
            end
            if (w_wr_window && !w_busy) r_window_n <= bus.writedata[CNT_W-1:0];

            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= w_cnt_next;

            if (w_latch) r_cumsum_out <= w_acc;
            r_cumsum_valid <= w_latch;

            // A latch colliding with a clear keeps done and counts as an overrun
            if (w_latch)         r_done <= 1'b1;
            else if (w_done_clr) r_done <= 1'b0;

            if (w_latch && (r_done || w_done_clr))
                r_overrun <= 1'b1;
            else if (w_wr_status && bus.writedata[c_STAT_OVERRUN])
                r_overrun <= 1'b0;

            if (w_acc_sat)
                r_sat <= 1'b1;
            else if (w_wr_status && bus.writedata[c_STAT_SAT])
                r_sat <= 1'b0;

            if (w_cfg_err_set)
                r_cfg_err <= 1'b1;
            else if (w_wr_status && bus.writedata[c_STAT_CFG_ERR])
                r_cfg_err <= 1'b0;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (bus.address)
            c_ADDR_CTRL: begin
                w_rd_mux[c_CTRL_CONT]   = r_continuous;
                w_rd_mux[c_CTRL_IRQ_EN] = r_irq_en;
            end
            c_ADDR_WINDOW: w_rd_mux[CNT_W-1:0] = r_window_n;
            c_ADDR_STATUS: begin
                w_rd_mux[c_STAT_BUSY]    = w_busy;
                w_rd_mux[c_STAT_DONE]    = r_done;
                w_rd_mux[c_STAT_OVERRUN] = r_overrun;
                w_rd_mux[c_STAT_SAT]     = r_sat;
                w_rd_mux[c_STAT_CFG_ERR] = r_cfg_err;
            end
            default: w_rd_mux[SUM_W-1:0] = r_cumsum_out;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)         r_readdata <= '0;
        else if (bus.read) r_readdata <= w_rd_mux;
    end

    assign bus.readdata  = r_readdata;
    assign cumsum_out    = r_cumsum_out;
    assign cumsum_valid  = r_cumsum_valid;
    assign irq           = r_done && r_irq_en;

endmodule

`default_nettype wire

// File: tb/tb_cumsum_window_ctrl.sv
// ============================================================================
// Module : tb_cumsum_window_ctrl
// Scoreboard bench: expected window sums queued at stimulus, popped on cumsum_valid
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cumsum_window_ctrl;
    import cumsum_pkg::*;

    localparam int     DATA_W  = 14;
    localparam int     SUM_W   = 28;
    localparam int     CNT_W   = 16;
    localparam longint SUM_MAX = (longint'(1) << SUM_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic [SUM_W-1:0]  cumsum_out;
    logic              cumsum_valid;
    logic              irq;

    int errors  = 0;
    int checks  = 0;
    int n_valid = 0;
    logic [SUM_W-1:0] exp_q[$];
    logic [SUM_W-1:0] m_exp;
    logic [SUM_W-1:0] last_result = '0;

    always #5 clk = ~clk;

    cumsum_window_ctrl_if bus ();

    cumsum_window_ctrl #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .cumsum_out   (cumsum_out),
        .cumsum_valid (cumsum_valid),
        .irq          (irq)
    );

    always @(negedge clk) begin
        if (!reset && cumsum_valid) begin
            n_valid++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL cumsum_unexpected: got %0h, no result queued", cumsum_out);
            end else begin
                m_exp = exp_q.pop_front();
                last_result = m_exp;
                if (cumsum_out !== m_exp) begin
                    errors++;
                    $display("FAIL cumsum_value: got %0h want %0h", cumsum_out, m_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.address   = a;
        bus.writedata = d;
        bus.write     = 1'b1;
        tick();
        bus.write     = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        bus.read    = 1'b1;
        tick();
        bus.read    = 1'b0;
        d           = bus.readdata;
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        bus.address = '0; bus.write = 1'b0; bus.writedata = '0; bus.read = 1'b0;
        sample_valid = 1'b0; sample_data = '0;
        repeat (3) tick();
        checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %0h want 0", bus.readdata); end
        checks++; if (cumsum_out !== '0) begin errors++; $display("FAIL reset_cumsum: got %0h want 0", cumsum_out); end
        checks++; if ({cumsum_valid, irq} !== 2'b00) begin errors++; $display("FAIL reset_valid_irq: got %b want 00", {cumsum_valid, irq}); end
        reset = 1'b0;
        tick();
        bus_read(c_ADDR_WINDOW, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL reset_window: got %0h want 1", d); end
        bus_read(c_ADDR_STATUS, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %0h want 0", d); end
        bus_read(c_ADDR_CTRL, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %0h want 0", d); end
    endtask

    task automatic test_single();
        logic [31:0] d;
        int          v0 = n_valid;
        int          s[4] = '{1, 2, 3, 4};
        longint      sum = 0;
        foreach (s[i]) sum += s[i];
        bus_write(c_ADDR_WINDOW, 32'd4);
        bus_write(c_ADDR_CTRL, 32'h9);
        exp_q.push_back(SUM_W'(sum));
        send(DATA_W'(s[0])); tick();
        send(DATA_W'(s[1])); tick(); tick();
        send(DATA_W'(s[2])); send(DATA_W'(s[3]));
        repeat (4) tick();
        checks++; if (n_valid != v0 + 1) begin errors++; $display("FAIL single_pulses: got %0d want %0d", n_valid - v0, 1); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL single_irq: got %b want 1", irq); end
        bus_read(c_ADDR_STATUS, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL single_status: got %0h want 2", d); end
        bus_read(c_ADDR_RESULT, d);
        checks++; if (d !== 32'd10) begin errors++; $display("FAIL single_result: got %0h want a", d); end
        bus_read(c_ADDR_STATUS, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL single_done_clr: got %0h want 0", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_clr: got %b want 0", irq); end
    endtask

    task automatic test_saturation();
        logic [31:0] d;
        longint      acc = 0;
        int          v0 = n_valid;
        bus_write(c_ADDR_WINDOW, 32'd65535);
        bus_write(c_ADDR_CTRL, 32'h1);
        for (int i = 0; i < 65535; i++) begin
            acc += 64'h3FFF;
            if (acc > SUM_MAX) acc = SUM_MAX;
        end
        exp_q.push_back(SUM_W'(acc));
        sample_valid = 1'b1;
        sample_data  = 14'h3FFF;
        repeat (65535) tick();
        sample_valid = 1'b0;
        repeat (3) tick();
        checks++; if (n_valid != v0 + 1) begin errors++; $display("FAIL sat_pulses: got %0d want 1", n_valid - v0); end
        checks++; if (cumsum_out !== 28'hFFFFFFF) begin errors++; $display("FAIL sat_value: got %0h want fffffff", cumsum_out); end
        bus_read(c_ADDR_STATUS, d);
        checks++; if (d !== 32'hA) begin errors++; $display("FAIL sat_status: got %0h want a", d); end
        bus_write(c_ADDR_STATUS, 32'h1E);
        bus_read(c_ADDR_STATUS, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL sat_w1c: got %0h want 0", d); end
    endtask

    task automatic test_continuous();
        logic [31:0] d;
        int          v0 = n_valid;
        bus_write(c_ADDR_WINDOW, 32'd2);
        bus_write(c_ADDR_CTRL, 32'h3);
        exp_q.push_back(28'd10);
        exp_q.push_back(28'd14);
        // The 100 lands in the LATCH cycle and must not count
        send(5); send(5); send(100); send(7); send(7);
        repeat (3) tick();
        checks++; if (n_valid != v0 + 2) begin errors++; $display("FAIL cont_pulses: got %0d want 2", n_valid - v0); end
        bus_read(c_ADDR_STATUS, d);
        checks++; if (d !== 32'h7) begin errors++; $display("FAIL cont_status: got %0h want 7", d); end
        bus_write(c_ADDR_CTRL, 32'h0);
        exp_q.push_back(28'd3);
        send(1); send(2);
        repeat (3) tick();
        bus_read(c_ADDR_STATUS, d);
        checks++; if (d !== 32'h6) begin errors++; $display("FAIL cont_stop: got %0h want 6", d); end
        bus_write(c_ADDR_STATUS, 32'h1E);
    endtask

    task automatic test_abort();
        logic [31:0]      d;
        logic [SUM_W-1:0] prior = last_result;
        int               v0 = n_valid;
        bus_write(c_ADDR_WINDOW, 32'd8);
        bus_write(c_ADDR_CTRL, 32'h1);
        send(9); send(9);
        bus_write(c_ADDR_CTRL, 32'h4);
        send(9); send(9); send(9); send(9); send(9); send(9);
        tick();
        bus_read(c_ADDR_STATUS, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL abort_status: got %0h want 0", d); end
        checks++; if (cumsum_out !== prior) begin errors++; $display("FAIL abort_hold: got %0h want %0h", cumsum_out, prior); end
        checks++; if (n_valid != v0) begin errors++; $display("FAIL abort_pulses: got %0d want 0", n_valid - v0); end
        bus_write(c_ADDR_WINDOW, 32'd0);
        bus_write(c_ADDR_CTRL, 32'h1);
        bus_read(c_ADDR_STATUS, d);
        checks++; if (d !== 32'h10) begin errors++; $display("FAIL cfg_err: got %0h want 10", d); end
        bus_write(c_ADDR_WINDOW, 32'd3);
        bus_write(c_ADDR_CTRL, 32'h5);
        bus_read(c_ADDR_STATUS, d);
        checks++; if (d !== 32'h10) begin errors++; $display("FAIL abort_over_start: got %0h want 10", d); end
        bus_write(c_ADDR_STATUS, 32'h1E);
    endtask

    task automatic test_read_collision();
        logic [31:0]      d;
        logic [SUM_W-1:0] prior = last_result;
        bus_write(c_ADDR_WINDOW, 32'd1);
        bus_write(c_ADDR_CTRL, 32'h1);
        exp_q.push_back(28'd6);
        send(6);
        bus_read(c_ADDR_RESULT, d);
        checks++; if (d !== {4'h0, prior}) begin errors++; $display("FAIL collide_old_read: got %0h want %0h", d, prior); end
        tick();
        bus_read(c_ADDR_STATUS, d);
        checks++; if (d !== 32'h6) begin errors++; $display("FAIL collide_status: got %0h want 6", d); end
        bus_read(c_ADDR_RESULT, d);
        checks++; if (d !== 32'd6) begin errors++; $display("FAIL collide_new_read: got %0h want 6", d); end
        bus_write(c_ADDR_STATUS, 32'h1E);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bus_write(c_ADDR_WINDOW, 32'd4);
        bus_write(c_ADDR_CTRL, 32'h1);
        send(3); send(3);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        bus_read(c_ADDR_STATUS, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rstmid_status: got %0h want 0", d); end
        checks++; if (cumsum_out !== '0) begin errors++; $display("FAIL rstmid_cumsum: got %0h want 0", cumsum_out); end
        bus_write(c_ADDR_CTRL, 32'h1);
        exp_q.push_back(28'd9);
        send(9);
        repeat (3) tick();
        checks++; if (cumsum_out !== 28'd9) begin errors++; $display("FAIL rstmid_result: got %0h want 9", cumsum_out); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturation();
        test_continuous();
        test_abort();
        test_read_collision();
        test_reset_mid();
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_results: got %0d unmatched, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cumsum_window_ctrl.md
CUMSUM_WINDOW_CTRL -- requirements
Module: cumsum_window_ctrl

Interface
REQ-001 Parameters: DATA_W default 14, ADC sample width; SUM_W default 28, accumulator/result width; CNT_W default 16, window-length counter width.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports:
  clk  in  1  system clock, all logic on rising edge.
  reset  in  1  synchronous active-high reset.
  address  in  2  Avalon-MM word address: 0 CTRL, 1 WINDOW, 2 STATUS, 3 RESULT.
  write  in  1  Avalon-MM write strobe.
  writedata  in  32  Avalon-MM write data.
  read  in  1  Avalon-MM read strobe.
  readdata  out  32  registered read data, zero-extended.
  sample_valid  in  1  ADC sample qualifier.
  sample_data  in  DATA_W  unsigned ADC sample.
  cumsum_out  out  SUM_W  last completed window sum, drives the HPS cumsum PIO input.
  cumsum_valid  out  1  one-cycle pulse when cumsum_out updates.
  irq  out  1  level interrupt = STATUS.done AND CTRL.irq_en.

Function
REQ-010 CTRL (R/W): bit0 start (write-1 pulse, reads 0), bit1 continuous, bit2 abort (write-1 pulse, reads 0), bit3 irq_en.
REQ-011 WINDOW (R/W): bits CNT_W-1:0 = N, samples per window; writes while busy SHALL be ignored.
REQ-012 STATUS (R): bit0 busy, bit1 done, bit2 overrun, bit3 sat, bit4 cfg_err; writing 1 to bits 1-4 clears them (W1C).
REQ-013 RESULT (R): cumsum_out zero-extended; a read SHALL clear done on the cycle after the read strobe.
REQ-014 Read latency SHALL be exactly 1 cycle: readdata updates on the edge after read is high, otherwise holds its last value.
REQ-015 FSM states: IDLE, ACCUM, LATCH.
REQ-016 IDLE -> ACCUM on start with N != 0: clear accumulator and sample counter, busy=1.
REQ-017 Start with N = 0 SHALL set cfg_err and remain in IDLE.
REQ-018 In ACCUM, each cycle with sample_valid=1 SHALL add sample_data to the accumulator and increment the counter; cycles with sample_valid=0 change nothing.
REQ-019 ACCUM -> LATCH on the cycle the N-th sample is accepted (that sample included).
REQ-020 LATCH (one cycle): cumsum_out <= accumulator, cumsum_valid=1, done=1; overrun set if done was already 1.
REQ-021 LATCH exit: -> ACCUM with cleared accumulator and counter if continuous=1, else -> IDLE with busy=0.
REQ-022 A sample arriving during LATCH SHALL be dropped; it is not counted toward the next window.
REQ-023 Arithmetic: unsigned add; on overflow the accumulator SHALL saturate at 2^SUM_W-1, set sat (sticky), and continue counting.
REQ-024 Abort in any state SHALL -> IDLE, busy=0, with no LATCH and cumsum_out unchanged; abort takes priority over start in the same write.
REQ-025 Start while busy SHALL be ignored.
REQ-026 A simultaneous done set (LATCH) and done clear (RESULT read or W1C) SHALL leave done=1 and SHALL set overrun.
REQ-027 Clearing continuous while busy SHALL take effect at the next LATCH exit.

Reset
REQ-030 On reset: FSM in IDLE; readdata, cumsum_out, accumulator, counter and all CTRL/STATUS bits 0; WINDOW N = 1; cumsum_valid=0, irq=0.
REQ-031 Reset asserted mid-window SHALL discard the partial sum with no LATCH.

Structure
REQ-040 A shared package cumsum_pkg SHALL hold: register address constants, STATUS/CTRL bit indices, the FSM state enum, and the default parameter values.
REQ-041 One sub-module, cumsum_sat_acc (saturating accumulator with clear, enable and sat flag), SHALL be instantiated; register decode and FSM stay in the top module.

Verification
REQ-050 N=4, single-shot, samples 1,2,3,4 with gaps in sample_valid -> one cumsum_valid pulse, cumsum_out=10, done=1, busy=0, irq=1 when irq_en=1.
REQ-051 N=65535, all samples 0x3FFF -> cumsum_out=0xFFFFFFF, sat=1.
REQ-052 Continuous mode, N=2, samples 5,5,7,7, result not read between windows -> cumsum_out 10 then 14, overrun=1.
REQ-053 Abort after 2 of N=8 samples -> busy=0, no cumsum_valid, cumsum_out retains its prior value; a following start with N=0 -> cfg_err=1, busy=0.
REQ-054 Read of RESULT in the same cycle as LATCH -> done remains 1, overrun=1; readdata returns the new value on the next read with 1-cycle latency.
REQ-055 Reset asserted mid-ACCUM, then start with N=1 and a sample of 9 -> cumsum_out=9, with no residue from the aborted window.
